// File: rtl/elevator_controller.sv
// Eight-floor elevator controller with one-hot floor encoding.
// Four-state FSM (IDLE, UP, DOWN, DOOR). Every output is a register.
// Floor shifts saturate at floors 0 and 7.
module elevator_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] request_floor,
  input  logic [7:0] in_current_floor,
  input  logic       over_time,
  input  logic       over_weight,
  output logic       direction,
  output logic [7:0] out_current_floor,
  output logic       complete,
  output logic       door_alert,
  output logic       weight_alert
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    DOOR = 2'd3
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] target_r;
  logic [7:0] target_nxt_s;
  logic [7:0] pos_nxt_s;
  logic [7:0] ref_pos_s;
  logic [7:0] pos_up_s;
  logic [7:0] pos_dn_s;
  logic       dir_nxt_s;
  logic       complete_nxt_s;
  logic       door_alert_nxt_s;
  logic       weight_alert_nxt_s;
  logic       req_valid_s;
  logic       sensor_valid_s;
  logic       accept_s;

  // A floor code is usable only when exactly one bit is set.
  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
  endfunction

  // Input qualification, reference position and saturating one-floor shifts.
  always_comb begin
    req_valid_s    = is_onehot(request_floor);
    sensor_valid_s = is_onehot(in_current_floor);
    accept_s       = req_valid_s && !over_weight;
    if (sensor_valid_s) begin
      ref_pos_s = in_current_floor;
    end else begin
      ref_pos_s = out_current_floor;
    end
    if (out_current_floor[7]) begin
      pos_up_s = out_current_floor;
    end else begin
      pos_up_s = {out_current_floor[6:0], 1'b0};
    end
    if (out_current_floor[0]) begin
      pos_dn_s = out_current_floor;
    end else begin
      pos_dn_s = {1'b0, out_current_floor[7:1]};
    end
  end

  // State and output registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r           <= IDLE;
      target_r          <= 8'h01;
      out_current_floor <= 8'h01;
      direction         <= 1'b0;
      complete          <= 1'b0;
      door_alert        <= 1'b0;
      weight_alert      <= 1'b0;
    end else begin
      state_r           <= state_nxt_s;
      target_r          <= target_nxt_s;
      out_current_floor <= pos_nxt_s;
      direction         <= dir_nxt_s;
      complete          <= complete_nxt_s;
      door_alert        <= door_alert_nxt_s;
      weight_alert      <= weight_alert_nxt_s;
    end
  end

  // Next-state logic. A move that could not advance (already saturated) falls back to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (request_floor > ref_pos_s) begin
            state_nxt_s = UP;
          end else if (request_floor < ref_pos_s) begin
            state_nxt_s = DOWN;
          end else begin
            state_nxt_s = DOOR;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      UP: begin
        if (over_weight) begin
          state_nxt_s = UP;
        end else if ((out_current_floor == target_r) || (pos_up_s == target_r)) begin
          state_nxt_s = DOOR;
        end else if (pos_up_s == out_current_floor) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = UP;
        end
      end
      DOWN: begin
        if (over_weight) begin
          state_nxt_s = DOWN;
        end else if ((out_current_floor == target_r) || (pos_dn_s == target_r)) begin
          state_nxt_s = DOOR;
        end else if (pos_dn_s == out_current_floor) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DOWN;
        end
      end
      DOOR: begin
        if (over_time || over_weight) begin
          state_nxt_s = DOOR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, position and latched target.
  always_comb begin
    pos_nxt_s          = out_current_floor;
    target_nxt_s       = target_r;
    dir_nxt_s          = direction;
    complete_nxt_s     = complete;
    door_alert_nxt_s   = over_time && ((state_r == IDLE) || (state_r == DOOR));
    weight_alert_nxt_s = over_weight;
    case (state_r)
      IDLE: begin
        if (sensor_valid_s) begin
          pos_nxt_s = in_current_floor;
        end else begin
          pos_nxt_s = out_current_floor;
        end
        if (accept_s) begin
          target_nxt_s   = request_floor;
          complete_nxt_s = (request_floor == ref_pos_s);
          if (request_floor > ref_pos_s) begin
            dir_nxt_s = 1'b1;
          end else if (request_floor < ref_pos_s) begin
            dir_nxt_s = 1'b0;
          end else begin
            dir_nxt_s = direction;
          end
        end else begin
          target_nxt_s = target_r;
        end
      end
      UP: begin
        if (over_weight) begin
          pos_nxt_s = out_current_floor;
        end else if (out_current_floor == target_r) begin
          complete_nxt_s = 1'b1;
        end else begin
          pos_nxt_s      = pos_up_s;
          complete_nxt_s = (pos_up_s == target_r);
        end
      end
      DOWN: begin
        if (over_weight) begin
          pos_nxt_s = out_current_floor;
        end else if (out_current_floor == target_r) begin
          complete_nxt_s = 1'b1;
        end else begin
          pos_nxt_s      = pos_dn_s;
          complete_nxt_s = (pos_dn_s == target_r);
        end
      end
      DOOR: begin
        pos_nxt_s = out_current_floor;
      end
      default: begin
        pos_nxt_s = out_current_floor;
      end
    endcase
  end

endmodule

// File: tb/tb_elevator_controller.sv
// Directed self-checking bench for elevator_controller.
module tb_elevator_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] request_floor = 8'h00;
  logic [7:0] in_current_floor = 8'h00;
  logic       over_time = 1'b0;
  logic       over_weight = 1'b0;
  logic       direction;
  logic [7:0] out_current_floor;
  logic       complete;
  logic       door_alert;
  logic       weight_alert;

  int vectors = 0;
  int miscompares = 0;

  elevator_controller dut (
    .clk(clk),
    .reset(reset),
    .request_floor(request_floor),
    .in_current_floor(in_current_floor),
    .over_time(over_time),
    .over_weight(over_weight),
    .direction(direction),
    .out_current_floor(out_current_floor),
    .complete(complete),
    .door_alert(door_alert),
    .weight_alert(weight_alert)
  );

  always #5 clk = ~clk;

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; over_time = 1'b1; over_weight = 1'b1;
    request_floor = 8'h10; in_current_floor = 8'h04;
    tick();
    vectors++;
    if ({out_current_floor, direction, complete, door_alert, weight_alert} !== {8'h01, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL reset_values: got pos=%h dir=%b cmp=%b da=%b wa=%b, expected pos=01 dir=0 cmp=0 da=0 wa=0",
               out_current_floor, direction, complete, door_alert, weight_alert);
      miscompares++;
    end
    reset = 1'b0; over_time = 1'b0; over_weight = 1'b0;
    request_floor = 8'h00; in_current_floor = 8'h00;
  endtask

  task automatic test_up();
    logic [7:0] exp_pos;
    logic       exp_c;
    in_current_floor = 8'h02; request_floor = 8'h10;
    tick();
    vectors++;
    if ({direction, out_current_floor, complete} !== {1'b1, 8'h02, 1'b0}) begin
      $display("FAIL up_accept: got dir=%b pos=%h cmp=%b, expected dir=1 pos=02 cmp=0", direction, out_current_floor, complete);
      miscompares++;
    end
    request_floor = 8'h00; in_current_floor = 8'h40;
    exp_pos = 8'h02;
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp_pos = exp_pos << 1;
      exp_c = (i == 3);
      vectors++;
      if ({out_current_floor, complete} !== {exp_pos, exp_c}) begin
        $display("FAIL up_step%0d: got pos=%h cmp=%b, expected pos=%h cmp=%b", i, out_current_floor, complete, exp_pos, exp_c);
        miscompares++;
      end
    end
    in_current_floor = 8'h00;
    tick();
    vectors++;
    if ({out_current_floor, complete, direction} !== {8'h10, 1'b1, 1'b1}) begin
      $display("FAIL up_hold: got pos=%h cmp=%b dir=%b, expected pos=10 cmp=1 dir=1", out_current_floor, complete, direction);
      miscompares++;
    end
  endtask

  task automatic test_down();
    logic [7:0] exp_pos;
    logic       exp_c;
    in_current_floor = 8'h20; request_floor = 8'h04;
    tick();
    vectors++;
    if ({direction, out_current_floor, complete} !== {1'b0, 8'h20, 1'b0}) begin
      $display("FAIL down_accept: got dir=%b pos=%h cmp=%b, expected dir=0 pos=20 cmp=0", direction, out_current_floor, complete);
      miscompares++;
    end
    request_floor = 8'h00; in_current_floor = 8'h00;
    exp_pos = 8'h20;
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp_pos = exp_pos >> 1;
      exp_c = (i == 3);
      vectors++;
      if ({out_current_floor, complete, direction} !== {exp_pos, exp_c, 1'b0}) begin
        $display("FAIL down_step%0d: got pos=%h cmp=%b dir=%b, expected pos=%h cmp=%b dir=0",
                 i, out_current_floor, complete, direction, exp_pos, exp_c);
        miscompares++;
      end
    end
    tick();
  endtask

  task automatic test_same_floor();
    in_current_floor = 8'h08; request_floor = 8'h08;
    tick();
    vectors++;
    if ({out_current_floor, complete, direction} !== {8'h08, 1'b1, 1'b0}) begin
      $display("FAIL same_floor: got pos=%h cmp=%b dir=%b, expected pos=08 cmp=1 dir=0", out_current_floor, complete, direction);
      miscompares++;
    end
    request_floor = 8'h00; in_current_floor = 8'h00;
    tick();
  endtask

  task automatic test_weight();
    in_current_floor = 8'h20; request_floor = 8'h04; over_weight = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if ({out_current_floor, complete, weight_alert} !== {8'h20, 1'b1, 1'b1}) begin
        $display("FAIL weight_block%0d: got pos=%h cmp=%b wa=%b, expected pos=20 cmp=1 wa=1",
                 i, out_current_floor, complete, weight_alert);
        miscompares++;
      end
    end
    over_weight = 1'b0;
    tick();
    vectors++;
    if ({out_current_floor, complete, weight_alert, direction} !== {8'h20, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL weight_release: got pos=%h cmp=%b wa=%b dir=%b, expected pos=20 cmp=0 wa=0 dir=0",
               out_current_floor, complete, weight_alert, direction);
      miscompares++;
    end
    request_floor = 8'h00; in_current_floor = 8'h00;
    tick();
    over_weight = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if ({out_current_floor, weight_alert, complete} !== {8'h10, 1'b1, 1'b0}) begin
        $display("FAIL weight_pause%0d: got pos=%h wa=%b cmp=%b, expected pos=10 wa=1 cmp=0",
                 i, out_current_floor, weight_alert, complete);
        miscompares++;
      end
    end
    over_weight = 1'b0;
    tick();
    tick();
    vectors++;
    if ({out_current_floor, complete, weight_alert} !== {8'h04, 1'b1, 1'b0}) begin
      $display("FAIL weight_resume: got pos=%h cmp=%b wa=%b, expected pos=04 cmp=1 wa=0", out_current_floor, complete, weight_alert);
      miscompares++;
    end
  endtask

  task automatic test_door_alert();
    over_time = 1'b1; request_floor = 8'h01; in_current_floor = 8'h00;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if ({door_alert, complete, out_current_floor} !== {1'b1, 1'b1, 8'h04}) begin
        $display("FAIL door_hold%0d: got da=%b cmp=%b pos=%h, expected da=1 cmp=1 pos=04",
                 i, door_alert, complete, out_current_floor);
        miscompares++;
      end
    end
    over_time = 1'b0;
    tick();
    tick();
    vectors++;
    if ({complete, direction, door_alert, out_current_floor} !== {1'b0, 1'b0, 1'b0, 8'h04}) begin
      $display("FAIL door_release: got cmp=%b dir=%b da=%b pos=%h, expected cmp=0 dir=0 da=0 pos=04",
               complete, direction, door_alert, out_current_floor);
      miscompares++;
    end
    request_floor = 8'h00; over_time = 1'b1;
    tick();
    vectors++;
    if ({door_alert, out_current_floor} !== {1'b0, 8'h02}) begin
      $display("FAIL door_moving: got da=%b pos=%h, expected da=0 pos=02", door_alert, out_current_floor);
      miscompares++;
    end
    over_time = 1'b0;
    tick();
    tick();
    over_time = 1'b1;
    tick();
    vectors++;
    if ({door_alert, complete, out_current_floor} !== {1'b1, 1'b1, 8'h01}) begin
      $display("FAIL door_idle_alert: got da=%b cmp=%b pos=%h, expected da=1 cmp=1 pos=01", door_alert, complete, out_current_floor);
      miscompares++;
    end
    over_time = 1'b0;
  endtask

  task automatic test_reset_mid_move();
    in_current_floor = 8'h01; request_floor = 8'h10;
    tick();
    in_current_floor = 8'h00;
    tick();
    tick();
    vectors++;
    if ({out_current_floor, direction} !== {8'h04, 1'b1}) begin
      $display("FAIL midmove_pre: got pos=%h dir=%b, expected pos=04 dir=1", out_current_floor, direction);
      miscompares++;
    end
    reset = 1'b1; over_weight = 1'b1; over_time = 1'b1;
    tick();
    vectors++;
    if ({out_current_floor, complete, direction, door_alert, weight_alert} !== {8'h01, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL midmove_reset: got pos=%h cmp=%b dir=%b da=%b wa=%b, expected pos=01 cmp=0 dir=0 da=0 wa=0",
               out_current_floor, complete, direction, door_alert, weight_alert);
      miscompares++;
    end
    reset = 1'b0; over_weight = 1'b0; over_time = 1'b0; in_current_floor = 8'h04;
    tick();
    vectors++;
    if ({out_current_floor, direction, complete} !== {8'h04, 1'b1, 1'b0}) begin
      $display("FAIL midmove_reaccept: got pos=%h dir=%b cmp=%b, expected pos=04 dir=1 cmp=0", out_current_floor, direction, complete);
      miscompares++;
    end
    request_floor = 8'h00; in_current_floor = 8'h00;
    tick();
    tick();
    vectors++;
    if ({out_current_floor, complete} !== {8'h10, 1'b1}) begin
      $display("FAIL midmove_arrive: got pos=%h cmp=%b, expected pos=10 cmp=1", out_current_floor, complete);
      miscompares++;
    end
    tick();
  endtask

  task automatic test_boundary();
    logic [7:0] exp_pos;
    logic       exp_c;
    in_current_floor = 8'h01; request_floor = 8'h80;
    tick();
    request_floor = 8'h00; in_current_floor = 8'h00;
    exp_pos = 8'h01;
    for (int i = 1; i <= 7; i++) begin
      tick();
      exp_pos = exp_pos << 1;
      exp_c = (i == 7);
      vectors++;
      if ({out_current_floor, complete} !== {exp_pos, exp_c}) begin
        $display("FAIL top_step%0d: got pos=%h cmp=%b, expected pos=%h cmp=%b", i, out_current_floor, complete, exp_pos, exp_c);
        miscompares++;
      end
    end
    tick();
    tick();
    vectors++;
    if (out_current_floor !== 8'h80) begin
      $display("FAIL top_no_wrap: got pos=%h, expected pos=80", out_current_floor);
      miscompares++;
    end
    request_floor = 8'h03; in_current_floor = 8'h03;
    tick();
    tick();
    vectors++;
    if ({out_current_floor, complete, direction} !== {8'h80, 1'b1, 1'b1}) begin
      $display("FAIL invalid_request: got pos=%h cmp=%b dir=%b, expected pos=80 cmp=1 dir=1", out_current_floor, complete, direction);
      miscompares++;
    end
    request_floor = 8'h40; in_current_floor = 8'h00;
    tick();
    request_floor = 8'h00;
    tick();
    vectors++;
    if ({out_current_floor, complete, direction} !== {8'h40, 1'b1, 1'b0}) begin
      $display("FAIL top_descend: got pos=%h cmp=%b dir=%b, expected pos=40 cmp=1 dir=0", out_current_floor, complete, direction);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_up();
    test_down();
    test_same_floor();
    test_weight();
    test_door_alert();
    test_reset_mid_move();
    test_boundary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
